// File: rtl/gate_stim_gen_if.sv
// Operand-stimulus bus between gate_stim_gen (master) and the gate test top (slave).
// Carries run control inputs plus the valid/ready vector handshake.
interface gate_stim_gen_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_vectors;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [CNT_W-1:0] vec_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, mode, seed, num_vectors, ready,
    output valid, in1, in2, in3, vec_idx, busy, done
  );

  modport slave (
    output start, mode, seed, num_vectors, ready,
    input  valid, in1, in2, in3, vec_idx, busy, done
  );
endinterface

// File: rtl/gate_stim_gen.sv
// On-chip operand generator: emits num_vectors LFSR / walking-one / counting vectors
// over valid/ready; vector 0 appears one cycle after start, outputs held while stalled.
module gate_stim_gen #(
  parameter int          WIDTH = 64,
  parameter int          CNT_W = 16,
  parameter logic [63:0] POLY  = 64'hD800_0000_0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_stim_gen_if.master bus
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = POLY[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
  } vec_t;

  // Mode 3 is reserved and falls through to the LFSR arm.
  function automatic vec_t pattern(input logic [1:0] m, input logic [WIDTH-1:0] s,
                                   input logic [KW-1:0] k);
    vec_t             v;
    logic [WIDTH-1:0] w;
    v = '0;
    w = '0;
    case (m)
      2'd1: begin
        w[k]  = 1'b1;
        v.in1 = w;
        v.in2 = ~w;
        v.in3 = {WIDTH{k[0]}};
      end
      2'd2: begin
        v.in1 = s;
        v.in2 = ~s;
        v.in3 = s + WIDTH'(1);
      end
      default: begin
        v.in1 = s;
        v.in2 = {s[WIDTH/2-1:0], s[WIDTH-1:WIDTH/2]};
        for (int i = 0; i < WIDTH; i++) v.in3[i] = s[WIDTH-1-i];
      end
    endcase
    return v;
  endfunction

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] s_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx_q;
  logic [KW-1:0]    k_q;
  vec_t             vec_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] s_init;
  logic [WIDTH-1:0] s_next;
  logic [KW-1:0]    k_next;
  logic             last;
  logic             lfsr_sel;

  always_comb begin
    lfsr_sel = (bus.mode != 2'd1) && (bus.mode != 2'd2);
    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    s_init   = (lfsr_sel && (bus.seed == '0)) ? WIDTH'(1) : bus.seed;
    case (mode_q)
      2'd1:    s_next = s_q;
      2'd2:    s_next = s_q + WIDTH'(1);
      default: s_next = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
    endcase
    // k tracks vec_idx mod WIDTH without a divider.
    k_next = (k_q == KW'(WIDTH - 1)) ? '0 : k_q + KW'(1);
    last   = (idx_q == n_q - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.num_vectors == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              mode_q  <= bus.mode;
              n_q     <= bus.num_vectors;
              s_q     <= s_init;
              idx_q   <= '0;
              k_q     <= '0;
              vec_q   <= pattern(bus.mode, s_init, '0);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.ready) begin
            if (last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + CNT_W'(1);
              s_q   <= s_next;
              k_q   <= k_next;
              vec_q <= pattern(mode_q, s_next, k_next);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.vec_idx = idx_q;
  assign bus.in1     = vec_q.in1;
  assign bus.in2     = vec_q.in2;
  assign bus.in3     = vec_q.in3;

endmodule

// File: doc/gate_stim_gen.md
# gate_stim_gen

Stimulus generator that sits directly upstream of the simple-gate test top and drives its three WIDTH-bit operand inputs (in1, in2, in3). On a start request it produces a programmed number of operand vectors from a selectable pattern source: Galois LFSR, walking-one or counting. Each vector is delivered over a valid/ready handshake, so the consumer can stall. It replaces per-cycle C-TB driving with on-chip pattern generation.

## Interface
- WIDTH, 64, operand width; must be ≥ 8 and even.
- CNT_W, 16, width of the vector count and index.
- POLY, 64'hD800_0000_0000_0000, Galois LFSR feedback mask (taps 64,63,61,60); only the low WIDTH bits are used.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- mode  in  2  pattern source: 0 LFSR, 1 walking-one, 2 counting, 3 reserved (behaves as LFSR); sampled with start.
- seed  in  WIDTH  LFSR seed / counting start value; sampled with start.
- num_vectors  in  CNT_W  vectors per run; sampled with start.
- ready  in  1  consumer accepts the current vector.
- valid  out  1  in1/in2/in3 hold a vector.
- in1, in2, in3  out  WIDTH each  operand vector.
- vec_idx  out  CNT_W  index of the presented vector, 0-based.
- busy  out  1  run in progress (RUN state).
- done  out  1  one-cycle pulse at end of run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: start=1 and num_vectors≠0. Latch mode, N=num_vectors and state S. S=seed, except LFSR mode with seed=0, which uses S=1.
- IDLE → DONE: start=1 and num_vectors=0. No vector is emitted.
- RUN → DONE: transfer (valid&ready) with vec_idx=N−1.
- DONE → IDLE: unconditionally after one cycle.
- start outside IDLE is ignored. Inputs sampled with start may change freely during a run.
- On each transfer: vec_idx increments and S advances to the next vector.

Pattern per mode, from current state S and k = vec_idx mod WIDTH:
- LFSR:
  - in1 = S; in2 = S rotated left by WIDTH/2; in3 = bit-reverse of S.
  - Next S = (S>>1) ^ (S[0] ? POLY : 0).
- Walking-one:
  - in1 = 1<<k; in2 = ~in1; in3 = all-ones if k odd, else zero.
  - S is unused.
- Counting:
  - in1 = S; in2 = ~S; in3 = S + 1 (mod 2^WIDTH).
  - Next S = S + 1, wrapping from all-ones to 0.
- vec_idx is CNT_W bits wide and never wraps inside a run, since N ≤ 2^CNT_W−1.

## Timing
- Reset (asynchronous, immediate, including mid-run): state IDLE; valid, busy, done, vec_idx, in1, in2, in3 all 0.
- Start latency: start high at edge t gives valid=1, busy=1 and vector 0 on outputs after t.
- Handshake:
  - While valid=1 and ready=0, in1/in2/in3/vec_idx are held stable.
  - valid never drops until the final transfer.
  - With ready held at 1, one vector transfers per cycle.
- Final transfer at edge t: after t, valid=0, busy=0, done=1, outputs return to 0. After t+1, done=0 and state is IDLE.
- The earliest next start is sampled in the cycle after done.
- Zero-count start at edge t: done=1 after t, with valid and busy staying 0.
- ready while valid=0 is ignored.

## Test plan
- Reset mid-run: assert rst_n=0 during RUN without a clock edge -> valid/busy/done/outputs 0 immediately; after release, no vector until a new start.
- LFSR, seed=1, N=3, ready=1 -> in1 = 0x1, 0xD800000000000000, 0x6C00000000000000. For the first vector, in2=0x0000000100000000 and in3=0x8000000000000000. Then done pulse one cycle after the last transfer.
- Walking-one, N=66, ready=1 -> in1 sequence 0x1, 0x2 … 0x8000000000000000, 0x1, 0x2. in2=~in1. in3 alternates 0 / all-ones. vec_idx 0…65.
- Counting, seed=0xFFFFFFFFFFFFFFFE, N=3, ready toggled 1,0,0,1,… -> in1 = …FE, …FF, 0x0. Each value is held stable across the ready=0 stall cycles. in3 of the second vector = 0x0.
- Edge cases: start with num_vectors=0 -> done=1 for one cycle, valid never asserted. Separately, start pulses during RUN are ignored, so an N=2 run yields exactly 2 transfers. Separately, LFSR seed=0 -> first in1=0x1.
